// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - writeback stage result/register-file bus and ALU result record
package wb_stage_pkg;
    typedef struct packed {
        logic        do_branch;
        logic [31:0] branch_target;
        logic        icache_invalidate;
        logic        register_write;
        logic [4:0]  rd;
        logic [31:0] exe_result;
    } alu_wb_inf_t;
endpackage

interface wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    import wb_stage_pkg::*;

    logic             alu_valid;
    alu_wb_inf_t      alu_wb_inf;
    logic             lsu_valid;
    logic             lsu_register_write;
    logic [4:0]       lsu_rd;
    logic [XLEN-1:0]  lsu_result;
    logic             lsu_ready;
    logic             mdu_valid;
    logic [4:0]       mdu_rd;
    logic [XLEN-1:0]  mdu_result;
    logic             mdu_ready;
    logic             rf_write_en;
    logic [4:0]       rf_rd;
    logic [XLEN-1:0]  rf_wdata;
    logic             wb_do_branch;
    logic [31:0]      wb_branch_target;
    logic             wb_icache_invalidate;
    logic [CNT_W-1:0] instret;

    // master: the execution units and consumers around the stage
    modport master (
        output alu_valid, alu_wb_inf,
        output lsu_valid, lsu_register_write, lsu_rd, lsu_result,
        output mdu_valid, mdu_rd, mdu_result,
        input  lsu_ready, mdu_ready,
        input  rf_write_en, rf_rd, rf_wdata,
        input  wb_do_branch, wb_branch_target, wb_icache_invalidate,
        input  instret
    );

    // slave: the writeback stage itself
    modport slave (
        input  alu_valid, alu_wb_inf,
        input  lsu_valid, lsu_register_write, lsu_rd, lsu_result,
        input  mdu_valid, mdu_rd, mdu_result,
        output lsu_ready, mdu_ready,
        output rf_write_en, rf_rd, rf_wdata,
        output wb_do_branch, wb_branch_target, wb_icache_invalidate,
        output instret
    );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback merge of ALU/LSU/MDU results, redirect pulse and retire counter
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus
);
    logic            lsu_buf_valid;
    logic            lsu_buf_we;
    logic [4:0]      lsu_buf_rd;
    logic [XLEN-1:0] lsu_buf_data;
    logic            mdu_buf_valid;
    logic [4:0]      mdu_buf_rd;
    logic [XLEN-1:0] mdu_buf_data;

    logic            alu_live;
    logic            lsu_take;
    logic            lsu_cand;
    logic            mdu_take;
    logic            mdu_cand;
    logic            lsu_win;
    logic            mdu_win;
    logic            win;
    logic            win_we;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic            redirect;

    assign bus.lsu_ready = !lsu_buf_valid;
    assign bus.mdu_ready = !mdu_buf_valid;

    // An ALU result presented during the redirect pulse is younger than the branch.
    assign alu_live = bus.alu_valid && !bus.wb_do_branch;
    assign lsu_take = bus.lsu_valid && !lsu_buf_valid;
    assign mdu_take = bus.mdu_valid && !mdu_buf_valid;
    assign lsu_cand = lsu_buf_valid || lsu_take;
    assign mdu_cand = mdu_buf_valid || mdu_take;
    assign lsu_win  = !alu_live && lsu_cand;
    assign mdu_win  = !alu_live && !lsu_cand && mdu_cand;
    assign win      = alu_live || lsu_win || mdu_win;
    assign redirect = alu_live && bus.alu_wb_inf.do_branch;

    always_comb begin
        win_we   = 1'b0;
        win_rd   = 5'd0;
        win_data = '0;
        if (alu_live) begin
            win_we   = bus.alu_wb_inf.register_write;
            win_rd   = bus.alu_wb_inf.rd;
            win_data = XLEN'(bus.alu_wb_inf.exe_result);
        end else if (lsu_win) begin
            win_we   = lsu_buf_valid ? lsu_buf_we   : bus.lsu_register_write;
            win_rd   = lsu_buf_valid ? lsu_buf_rd   : bus.lsu_rd;
            win_data = lsu_buf_valid ? lsu_buf_data : bus.lsu_result;
        end else if (mdu_win) begin
            win_we   = 1'b1;
            win_rd   = mdu_buf_valid ? mdu_buf_rd   : bus.mdu_rd;
            win_data = mdu_buf_valid ? mdu_buf_data : bus.mdu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_buf_valid            <= 1'b0;
            lsu_buf_we               <= 1'b0;
            lsu_buf_rd               <= 5'd0;
            lsu_buf_data             <= '0;
            mdu_buf_valid            <= 1'b0;
            mdu_buf_rd               <= 5'd0;
            mdu_buf_data             <= '0;
            bus.rf_write_en          <= 1'b0;
            bus.rf_rd                <= 5'd0;
            bus.rf_wdata             <= '0;
            bus.wb_do_branch         <= 1'b0;
            bus.wb_branch_target     <= 32'd0;
            bus.wb_icache_invalidate <= 1'b0;
            bus.instret              <= '0;
        end else begin
            // A losing live input parks in its buffer; a winning buffer drains.
            if (lsu_buf_valid && lsu_win) begin
                lsu_buf_valid <= 1'b0;
            end else if (lsu_take && !lsu_win) begin
                lsu_buf_valid <= 1'b1;
                lsu_buf_we    <= bus.lsu_register_write;
                lsu_buf_rd    <= bus.lsu_rd;
                lsu_buf_data  <= bus.lsu_result;
            end

            if (mdu_buf_valid && mdu_win) begin
                mdu_buf_valid <= 1'b0;
            end else if (mdu_take && !mdu_win) begin
                mdu_buf_valid <= 1'b1;
                mdu_buf_rd    <= bus.mdu_rd;
                mdu_buf_data  <= bus.mdu_result;
            end

            bus.rf_write_en <= win && win_we && (win_rd != 5'd0);
            if (win) begin
                bus.rf_rd    <= win_rd;
                bus.rf_wdata <= win_data;
                bus.instret  <= bus.instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            bus.wb_do_branch         <= redirect;
            bus.wb_icache_invalidate <= redirect && bus.alu_wb_inf.icache_invalidate;
            if (redirect) begin
                bus.wb_branch_target <= bus.alu_wb_inf.branch_target;
            end
        end
    end
endmodule
